// File: rtl/matrix_cmd_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_cmd_sched_if                                                        |
// | Command, stack-block and multiplier signals of the matrix command sequencer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface matrix_cmd_sched_if #(
  parameter int DW = 128
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] peek_0, peek_1, peek_2, peek_3;
  logic          mc_matrix_mode;
  logic          mc_load_id_en, mc_load_en, mc_pop_en, mc_write_en, mc_push_en;
  logic [DW-1:0] mc_data_in;
  logic [DW-1:0] mc_write_in_0, mc_write_in_1, mc_write_in_2, mc_write_in_3;
  logic          mul_start;
  logic [DW-1:0] mul_b_0, mul_b_1, mul_b_2, mul_b_3;
  logic          mul_done;
  logic [DW-1:0] mul_res_0, mul_res_1, mul_res_2, mul_res_3;
  logic          busy;
  logic [5:0]    mv_depth;
  logic [1:0]    pj_depth;
  logic          err_ovf, err_unf, err_ill;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, peek_0, peek_1, peek_2, peek_3,
           mul_done, mul_res_0, mul_res_1, mul_res_2, mul_res_3,
    output cmd_ready, mc_matrix_mode, mc_load_id_en, mc_load_en, mc_pop_en,
           mc_write_en, mc_push_en, mc_data_in,
           mc_write_in_0, mc_write_in_1, mc_write_in_2, mc_write_in_3,
           mul_start, mul_b_0, mul_b_1, mul_b_2, mul_b_3,
           busy, mv_depth, pj_depth, err_ovf, err_unf, err_ill
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, peek_0, peek_1, peek_2, peek_3,
           mul_done, mul_res_0, mul_res_1, mul_res_2, mul_res_3,
    input  cmd_ready, mc_matrix_mode, mc_load_id_en, mc_load_en, mc_pop_en,
           mc_write_en, mc_push_en, mc_data_in,
           mc_write_in_0, mc_write_in_1, mc_write_in_2, mc_write_in_3,
           mul_start, mul_b_0, mul_b_1, mul_b_2, mul_b_3,
           busy, mv_depth, pj_depth, err_ovf, err_unf, err_ill
  );
endinterface
`default_nettype wire

// File: rtl/matrix_cmd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_cmd_sched                                                           |
// | Single-issue sequencer: GL matrix commands -> matrix stack and multiplier  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module matrix_cmd_sched #(
  parameter int DW       = 128,
  parameter int MV_DEPTH = 32,
  parameter int PJ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  matrix_cmd_sched_if.slave bus
);
  localparam logic [2:0] c_OP_MODE    = 3'd1;
  localparam logic [2:0] c_OP_LOAD_ID = 3'd2;
  localparam logic [2:0] c_OP_LOAD    = 3'd3;
  localparam logic [2:0] c_OP_MULT    = 3'd4;
  localparam logic [2:0] c_OP_PUSH    = 3'd5;
  localparam logic [2:0] c_OP_POP     = 3'd6;
  localparam logic [2:0] c_OP_ILL     = 3'd7;
  localparam logic [5:0] c_MV_CAP     = 6'(MV_DEPTH);
  localparam logic [5:0] c_PJ_CAP     = 6'(PJ_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_COLLECT = 4'd1,
    S_PCAP    = 4'd2,
    S_PLOAD0  = 4'd3,
    S_PLOAD1  = 4'd4,
    S_PLOAD2  = 4'd5,
    S_PLOAD3  = 4'd6,
    S_MWAIT   = 4'd7,
    S_WR      = 4'd8,
    S_SETTLE  = 4'd9
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mode, w_mode_nxt;
  logic [DW-1:0] r_buf [4];
  logic [DW-1:0] w_buf_nxt [4];
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic          r_is_mult, w_is_mult_nxt;
  logic [5:0]    r_mv_depth, w_mv_depth_nxt;
  logic [1:0]    r_pj_depth, w_pj_depth_nxt;
  logic          r_load_id_en, w_load_id_en_nxt;
  logic          r_load_en, w_load_en_nxt;
  logic          r_pop_en, w_pop_en_nxt;
  logic          r_write_en, w_write_en_nxt;
  logic          r_mul_start, w_mul_start_nxt;
  logic          r_err_ovf, w_err_ovf_nxt;
  logic          r_err_unf, w_err_unf_nxt;
  logic          r_err_ill, w_err_ill_nxt;
  logic [DW-1:0] r_data_in, w_data_in_nxt;
  logic          w_accept;
  logic [5:0]    w_depth_cur, w_cap;

  assign bus.cmd_ready = (r_state == S_IDLE) || (r_state == S_COLLECT);
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_depth_cur   = r_mode ? {4'd0, r_pj_depth} : r_mv_depth;
  assign w_cap         = r_mode ? c_PJ_CAP : c_MV_CAP;

  always_comb begin
    w_state_nxt      = r_state;
    w_mode_nxt       = r_mode;
    w_buf_nxt        = r_buf;
    w_cnt_nxt        = r_cnt;
    w_is_mult_nxt    = r_is_mult;
    w_mv_depth_nxt   = r_mv_depth;
    w_pj_depth_nxt   = r_pj_depth;
    w_load_id_en_nxt = 1'b0;
    w_load_en_nxt    = 1'b0;
    w_pop_en_nxt     = 1'b0;
    w_write_en_nxt   = 1'b0;
    w_mul_start_nxt  = 1'b0;
    w_err_ovf_nxt    = 1'b0;
    w_err_unf_nxt    = 1'b0;
    w_err_ill_nxt    = 1'b0;
    w_data_in_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            c_OP_MODE: w_mode_nxt = bus.cmd_data[0];
            c_OP_LOAD_ID: begin
              w_load_id_en_nxt = 1'b1;
              w_state_nxt      = S_SETTLE;
            end
            c_OP_LOAD, c_OP_MULT: begin
              w_buf_nxt[0]  = bus.cmd_data;
              w_cnt_nxt     = 2'd1;
              w_is_mult_nxt = (bus.cmd_op == c_OP_MULT);
              w_state_nxt   = S_COLLECT;
            end
            c_OP_PUSH: begin
              if (w_depth_cur == w_cap) w_err_ovf_nxt = 1'b1;
              else                      w_state_nxt   = S_PCAP;
            end
            c_OP_POP: begin
              if (w_depth_cur == 6'd1) begin
                w_err_unf_nxt = 1'b1;
              end else begin
                w_pop_en_nxt = 1'b1;
                if (r_mode) w_pj_depth_nxt = r_pj_depth - 2'd1;
                else        w_mv_depth_nxt = r_mv_depth - 6'd1;
                w_state_nxt = S_SETTLE;
              end
            end
            c_OP_ILL: w_err_ill_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      S_COLLECT: begin
        if (w_accept) begin
          w_buf_nxt[r_cnt] = bus.cmd_data;
          if (r_cnt == 2'd3) begin
            if (r_is_mult) begin
              w_mul_start_nxt = 1'b1;
              w_state_nxt     = S_MWAIT;
            end else begin
              w_write_en_nxt = 1'b1;
              w_state_nxt    = S_WR;
            end
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      S_PCAP: begin
        // Snapshot the old top so the load sequence replays it after the push.
        w_buf_nxt[0]  = bus.peek_0;
        w_buf_nxt[1]  = bus.peek_1;
        w_buf_nxt[2]  = bus.peek_2;
        w_buf_nxt[3]  = bus.peek_3;
        w_data_in_nxt = bus.peek_0;
        w_load_en_nxt = 1'b1;
        if (r_mode) w_pj_depth_nxt = r_pj_depth + 2'd1;
        else        w_mv_depth_nxt = r_mv_depth + 6'd1;
        w_state_nxt   = S_PLOAD0;
      end
      S_PLOAD0: begin
        w_data_in_nxt = r_buf[1];
        w_state_nxt   = S_PLOAD1;
      end
      S_PLOAD1: begin
        w_data_in_nxt = r_buf[2];
        w_state_nxt   = S_PLOAD2;
      end
      S_PLOAD2: begin
        w_data_in_nxt = r_buf[3];
        w_state_nxt   = S_PLOAD3;
      end
      // Row 3 lands at the end of PLOAD3; the following accept cycle gives peek time to settle.
      S_PLOAD3: w_state_nxt = S_IDLE;
      S_MWAIT: begin
        if (bus.mul_done) begin
          w_buf_nxt[0]   = bus.mul_res_0;
          w_buf_nxt[1]   = bus.mul_res_1;
          w_buf_nxt[2]   = bus.mul_res_2;
          w_buf_nxt[3]   = bus.mul_res_3;
          w_write_en_nxt = 1'b1;
          w_state_nxt    = S_WR;
        end
      end
      S_WR:     w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      for (int k = 0; k < 4; k++) r_buf[k] <= '0;
      r_cnt        <= 2'd0;
      r_is_mult    <= 1'b0;
      r_mv_depth   <= 6'd1;
      r_pj_depth   <= 2'd1;
      r_load_id_en <= 1'b0;
      r_load_en    <= 1'b0;
      r_pop_en     <= 1'b0;
      r_write_en   <= 1'b0;
      r_mul_start  <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_unf    <= 1'b0;
      r_err_ill    <= 1'b0;
      r_data_in    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_buf        <= w_buf_nxt;
      r_cnt        <= w_cnt_nxt;
      r_is_mult    <= w_is_mult_nxt;
      r_mv_depth   <= w_mv_depth_nxt;
      r_pj_depth   <= w_pj_depth_nxt;
      r_load_id_en <= w_load_id_en_nxt;
      r_load_en    <= w_load_en_nxt;
      r_pop_en     <= w_pop_en_nxt;
      r_write_en   <= w_write_en_nxt;
      r_mul_start  <= w_mul_start_nxt;
      r_err_ovf    <= w_err_ovf_nxt;
      r_err_unf    <= w_err_unf_nxt;
      r_err_ill    <= w_err_ill_nxt;
      r_data_in    <= w_data_in_nxt;
    end
  end

  assign bus.mc_matrix_mode = r_mode;
  assign bus.mc_load_id_en  = r_load_id_en;
  assign bus.mc_load_en     = r_load_en;
  assign bus.mc_pop_en      = r_pop_en;
  assign bus.mc_write_en    = r_write_en;
  assign bus.mc_push_en     = 1'b0;
  assign bus.mc_data_in     = r_data_in;
  assign bus.mc_write_in_0  = r_buf[0];
  assign bus.mc_write_in_1  = r_buf[1];
  assign bus.mc_write_in_2  = r_buf[2];
  assign bus.mc_write_in_3  = r_buf[3];
  assign bus.mul_start      = r_mul_start;
  assign bus.mul_b_0        = r_buf[0];
  assign bus.mul_b_1        = r_buf[1];
  assign bus.mul_b_2        = r_buf[2];
  assign bus.mul_b_3        = r_buf[3];
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.mv_depth       = r_mv_depth;
  assign bus.pj_depth       = r_pj_depth;
  assign bus.err_ovf        = r_err_ovf;
  assign bus.err_unf        = r_err_unf;
  assign bus.err_ill        = r_err_ill;
endmodule
`default_nettype wire

// File: tb/tb_matrix_cmd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_cmd_sched                                                        |
// | Directed bench with an enable/row scoreboard for matrix_cmd_sched          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_matrix_cmd_sched;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [2:0]        kind;  // 1 load_id, 2 load, 3 pop, 4 write
    logic [3:0][127:0] r;
  } exp_t;

  exp_t              q[$];
  logic [3:0][127:0] c_P, c_R, c_I, c_M, c_Z;
  int                tail;
  logic [3:0][127:0] tail_rows;

  matrix_cmd_sched_if #(.DW(128)) bus ();

  matrix_cmd_sched #(.DW(128), .MV_DEPTH(32), .PJ_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.peek_0 = c_P[0];
  assign bus.peek_1 = c_P[1];
  assign bus.peek_2 = c_P[2];
  assign bus.peek_3 = c_P[3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] k, input logic [3:0][127:0] r);
    exp_t e;
    e.kind = k;
    e.r    = r;
    return e;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 128'(n < 40), 128'(1));
  endtask

  // Called on a negedge; returns on the negedge of the cycle after acceptance.
  task automatic beat(input logic [2:0] op, input logic [127:0] d);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = '0;
  endtask

  task automatic set_res(input logic [3:0][127:0] r);
    bus.mul_res_0 = r[0];
    bus.mul_res_1 = r[1];
    bus.mul_res_2 = r[2];
    bus.mul_res_3 = r[3];
  endtask

  // Scoreboard: every stack enable must match the next expected entry.
  always @(negedge clk or posedge rst) begin
    int          nen;
    logic [2:0]  kind;
    exp_t        e;
    if (rst) begin
      tail = 0;
    end else begin
      nen = int'(bus.mc_load_id_en) + int'(bus.mc_load_en) + int'(bus.mc_pop_en)
          + int'(bus.mc_write_en) + int'(bus.mc_push_en);
      kind = bus.mc_load_id_en ? 3'd1 : bus.mc_load_en ? 3'd2 :
             bus.mc_pop_en ? 3'd3 : bus.mc_write_en ? 3'd4 : 3'd0;
      if (tail > 0) begin
        chk("load_row", bus.mc_data_in, tail_rows[4-tail]);
        chk("tail_no_en", 128'(nen), 128'(0));
        tail--;
      end else if (nen > 0) begin
        chk("onehot_en", 128'(nen), 128'(1));
        if (q.size() == 0) begin
          chk("unexpected_en", 128'(kind), 128'(0));
        end else begin
          e = q.pop_front();
          chk("en_kind", 128'(kind), 128'(e.kind));
          if (kind == 3'd4) begin
            chk("write_in_0", bus.mc_write_in_0, e.r[0]);
            chk("write_in_1", bus.mc_write_in_1, e.r[1]);
            chk("write_in_2", bus.mc_write_in_2, e.r[2]);
            chk("write_in_3", bus.mc_write_in_3, e.r[3]);
          end else if (kind == 3'd2) begin
            chk("load_row0", bus.mc_data_in, e.r[0]);
            tail      = 3;
            tail_rows = e.r;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    c_P[0] = 128'h3B4B295F_00000000_00000000_3F800000;
    c_P[1] = 128'h3B4B2960_3F800000_00000000_00000001;
    c_P[2] = 128'h3B4B2961_00000000_3F800000_00000002;
    c_P[3] = 128'h3B4B2962_00000000_00000000_3F800003;
    c_R[0] = 128'h11111111_22222222_33333333_44444444;
    c_R[1] = 128'h55555555_66666666_77777777_88888888;
    c_R[2] = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    c_R[3] = 128'hDDDDDDDD_EEEEEEEE_FFFFFFFF_01234567;
    c_I[0] = 128'h3F800000_00000000_00000000_00000000;
    c_I[1] = 128'h00000000_3F800000_00000000_00000000;
    c_I[2] = 128'h00000000_00000000_3F800000_00000000;
    c_I[3] = 128'h00000000_00000000_00000000_3F800000;
    c_M[0] = 128'h40000000_40400000_40800000_40A00000;
    c_M[1] = 128'h40C00000_40E00000_41000000_41100000;
    c_M[2] = 128'h41200000_41300000_41400000_41500000;
    c_M[3] = 128'h41600000_41700000_41800000_41880000;
    c_Z    = '1;
    rst = 1'b1;
    tail = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = '0;
    bus.mul_done  = 1'b0;
    set_res(c_Z);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 128'(bus.cmd_ready), 128'(1));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_mv_depth", 128'(bus.mv_depth), 128'(1));
    chk("rst_pj_depth", 128'(bus.pj_depth), 128'(1));
    chk("rst_mode", 128'(bus.mc_matrix_mode), 128'(0));
    chk("rst_push_en", 128'(bus.mc_push_en), 128'(0));
    chk("rst_data_in", bus.mc_data_in, 128'(0));
    chk("rst_write_in_0", bus.mc_write_in_0, 128'(0));

    // First PUSH: cmd_ready returns five cycles after the action cycle
    q.push_back(mk(3'd2, c_P));
    beat(3'd5, '0);
    chk("push_busy", 128'(bus.busy), 128'(1));
    begin
      int k;
      k = 0;
      while (bus.cmd_ready !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("push_ready_lat", 128'(k), 128'(5));
    end
    chk("mv_depth_2", 128'(bus.mv_depth), 128'(2));

    for (int i = 0; i < 30; i++) begin
      q.push_back(mk(3'd2, c_P));
      beat(3'd5, '0);
    end
    wait_ready();
    chk("mv_depth_full", 128'(bus.mv_depth), 128'(32));

    // Overflowing PUSH is dropped
    beat(3'd5, '0);
    chk("ovf_pulse", 128'(bus.err_ovf), 128'(1));
    chk("ovf_depth", 128'(bus.mv_depth), 128'(32));
    chk("ovf_busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    chk("ovf_pulse_end", 128'(bus.err_ovf), 128'(0));

    // Projection stack: underflow then a real push
    beat(3'd1, 128'(1));
    chk("mode_proj", 128'(bus.mc_matrix_mode), 128'(1));
    beat(3'd6, '0);
    chk("unf_pulse", 128'(bus.err_unf), 128'(1));
    chk("unf_depth", 128'(bus.pj_depth), 128'(1));
    q.push_back(mk(3'd2, c_P));
    beat(3'd5, '0);
    wait_ready();
    chk("pj_depth_2", 128'(bus.pj_depth), 128'(2));
    chk("mv_untouched", 128'(bus.mv_depth), 128'(32));

    // LOAD with 2-cycle gaps between beats
    q.push_back(mk(3'd4, c_R));
    beat(3'd3, c_R[0]);
    for (int r = 1; r < 4; r++) begin
      repeat (2) @(negedge clk);
      chk("collect_ready", 128'(bus.cmd_ready), 128'(1));
      beat(3'd0, c_R[r]);
    end
    chk("load_wr_en", 128'(bus.mc_write_en), 128'(1));
    chk("load_ready_m1", 128'(bus.cmd_ready), 128'(0));
    @(negedge clk);
    chk("load_ready_m2", 128'(bus.cmd_ready), 128'(0));
    @(negedge clk);
    chk("load_ready_m3", 128'(bus.cmd_ready), 128'(1));

    // Spurious mul_done in IDLE must not produce a write
    bus.mul_done = 1'b1;
    @(negedge clk);
    bus.mul_done = 1'b0;
    @(negedge clk);
    chk("spurious_busy", 128'(bus.busy), 128'(0));

    // MULT by identity, multiplier answers 7 cycles after start
    q.push_back(mk(3'd4, c_M));
    beat(3'd4, c_I[0]);
    beat(3'd0, c_I[1]);
    beat(3'd0, c_I[2]);
    beat(3'd0, c_I[3]);
    chk("mul_start", 128'(bus.mul_start), 128'(1));
    chk("mul_b_0", bus.mul_b_0, c_I[0]);
    chk("mul_b_1", bus.mul_b_1, c_I[1]);
    chk("mul_b_2", bus.mul_b_2, c_I[2]);
    chk("mul_b_3", bus.mul_b_3, c_I[3]);
    repeat (7) begin
      @(negedge clk);
      chk("mwait_no_start", 128'(bus.mul_start), 128'(0));
    end
    chk("mwait_busy", 128'(bus.busy), 128'(1));
    set_res(c_M);
    bus.mul_done = 1'b1;
    @(negedge clk);
    bus.mul_done = 1'b0;
    set_res(c_Z);
    chk("mul_wr_en", 128'(bus.mc_write_en), 128'(1));
    wait_ready();

    // LOAD_ID: one enable, ready two cycles after acceptance
    q.push_back(mk(3'd1, c_Z));
    beat(3'd2, '0);
    chk("ldid_en", 128'(bus.mc_load_id_en), 128'(1));
    chk("ldid_ready_n1", 128'(bus.cmd_ready), 128'(0));
    @(negedge clk);
    chk("ldid_ready_n2", 128'(bus.cmd_ready), 128'(1));
    chk("ldid_en_off", 128'(bus.mc_load_id_en), 128'(0));

    // Illegal opcode
    beat(3'd7, '0);
    chk("ill_pulse", 128'(bus.err_ill), 128'(1));
    chk("ill_busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    chk("ill_pulse_end", 128'(bus.err_ill), 128'(0));

    // Back to modelview, POP, then reset during PLOAD2
    beat(3'd1, 128'(0));
    chk("mode_mv", 128'(bus.mc_matrix_mode), 128'(0));
    q.push_back(mk(3'd3, c_Z));
    beat(3'd6, '0);
    chk("pop_en", 128'(bus.mc_pop_en), 128'(1));
    chk("pop_depth", 128'(bus.mv_depth), 128'(31));
    wait_ready();
    q.push_back(mk(3'd2, c_P));
    beat(3'd5, '0);
    @(negedge clk);
    chk("abort_load_en", 128'(bus.mc_load_en), 128'(1));
    repeat (2) @(negedge clk);
    chk("abort_in_pload2", 128'(bus.busy), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_load_en_off", 128'(bus.mc_load_en), 128'(0));
    chk("abort_data_in", bus.mc_data_in, 128'(0));
    chk("abort_busy", 128'(bus.busy), 128'(0));
    chk("abort_ready", 128'(bus.cmd_ready), 128'(1));
    chk("abort_mv_depth", 128'(bus.mv_depth), 128'(1));
    chk("abort_pj_depth", 128'(bus.pj_depth), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_abort_idle", 128'(bus.busy), 128'(0));
    chk("queue_empty", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
